// File: rtl/sm_mem_arbiter_pkg.sv
// rtl/sm_mem_arbiter_pkg.sv - FSM state encodings and port ids for the two-port memory arbiter
package sm_mem_arbiter_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;
  localparam state_t ST_RESP  = 2'd3;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/sm_arb2.sv
// rtl/sm_arb2.sv - combinational two-way grant; tie rule selected by SM_CONFIG_ARB_ROUND_ROBIN_EN
module sm_arb2 (
  input  logic s0_valid,
  input  logic s1_valid,
  input  logic last,
  output logic req,
  output logic grant
);

  assign req = s0_valid | s1_valid;

`ifdef SM_CONFIG_ARB_ROUND_ROBIN_EN
  // On a tie the port that was not served last wins; a lone requester always wins.
  always_comb begin
    grant = s1_valid;
    if (s0_valid && s1_valid) begin
      grant = ~last;
    end
  end
`else
  logic last_unused;
  assign last_unused = last;
  assign grant       = s1_valid;
`endif

endmodule

// File: rtl/sm_mem_arbiter.sv
// rtl/sm_mem_arbiter.sv - two-port arbiter/sequencer onto one valid/ready memory slave
// Tie rule: SM_CONFIG_ARB_ROUND_ROBIN_EN defined = round robin, undefined = port 1 priority.
module sm_mem_arbiter
  import sm_mem_arbiter_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] s0_a,
  input  logic          s0_we,
  input  logic [DW-1:0] s0_wd,
  input  logic          s0_valid,
  output logic          s0_ready,
  output logic [DW-1:0] s0_rd,
  input  logic [AW-1:0] s1_a,
  input  logic          s1_we,
  input  logic [DW-1:0] s1_wd,
  input  logic          s1_valid,
  output logic          s1_ready,
  output logic [DW-1:0] s1_rd,
  output logic [AW-1:0] m_a,
  output logic          m_we,
  output logic [DW-1:0] m_wd,
  output logic          m_valid,
  input  logic          m_ready,
  input  logic [DW-1:0] m_rd
);

  state_t        state_q, state_d;
  logic          grant_q, grant_d;
  logic          last_q, last_d;
  logic          s0_ready_q, s0_ready_d;
  logic          s1_ready_q, s1_ready_d;
  logic [DW-1:0] s0_rd_q, s0_rd_d;
  logic [DW-1:0] s1_rd_q, s1_rd_d;
  logic          arb_req;
  logic          arb_grant;

  sm_arb2 u_arb (
    .s0_valid (s0_valid),
    .s1_valid (s1_valid),
    .last     (last_q),
    .req      (arb_req),
    .grant    (arb_grant)
  );

  // Requesters hold their fields stable until ready, so the plain mux is safe.
  assign m_a     = (grant_q == PORT1) ? s1_a  : s0_a;
  assign m_we    = (grant_q == PORT1) ? s1_we : s0_we;
  assign m_wd    = (grant_q == PORT1) ? s1_wd : s0_wd;
  assign m_valid = (state_q == ST_ISSUE);

  assign s0_ready = s0_ready_q;
  assign s1_ready = s1_ready_q;
  assign s0_rd    = s0_rd_q;
  assign s1_rd    = s1_rd_q;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    s0_ready_d = 1'b0;
    s1_ready_d = 1'b0;
    s0_rd_d    = s0_rd_q;
    s1_rd_d    = s1_rd_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_req) begin
          grant_d = arb_grant;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (m_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // The strobe is registered here so it lands in the RESP cycle.
        if (m_ready) begin
          if (grant_q == PORT1) begin
            s1_ready_d = 1'b1;
            if (!m_we) s1_rd_d = m_rd;
          end else begin
            s0_ready_d = 1'b1;
            if (!m_we) s0_rd_d = m_rd;
          end
          state_d = ST_RESP;
        end
      end
      default: begin
        last_d  = grant_q;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= PORT0;
      last_q     <= PORT1;
      s0_ready_q <= 1'b0;
      s1_ready_q <= 1'b0;
      s0_rd_q    <= '0;
      s1_rd_q    <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      s0_ready_q <= s0_ready_d;
      s1_ready_q <= s1_ready_d;
      s0_rd_q    <= s0_rd_d;
      s1_rd_q    <= s1_rd_d;
    end
  end

endmodule

// File: tb/tb_sm_mem_arbiter.sv
// tb/tb_sm_mem_arbiter.sv - directed self-checking bench for sm_mem_arbiter with a behavioural slave
module tb_sm_mem_arbiter;

`ifdef SM_CONFIG_ARB_ROUND_ROBIN_EN
  localparam logic [3:0] TIE_EXP = 4'b0101;
`else
  localparam logic [3:0] TIE_EXP = 4'b1111;
`endif

  logic        clk;
  logic        rst_n;
  logic [31:0] s0_a, s1_a, s0_wd, s1_wd;
  logic        s0_we, s1_we, s0_valid, s1_valid;
  logic        s0_ready, s1_ready;
  logic [31:0] s0_rd, s1_rd;
  logic [31:0] m_a, m_wd, m_rd;
  logic        m_we, m_valid, m_ready;

  int n_checks = 0;
  int n_errors = 0;

  sm_mem_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s0_a     (s0_a),
    .s0_we    (s0_we),
    .s0_wd    (s0_wd),
    .s0_valid (s0_valid),
    .s0_ready (s0_ready),
    .s0_rd    (s0_rd),
    .s1_a     (s1_a),
    .s1_we    (s1_we),
    .s1_wd    (s1_wd),
    .s1_valid (s1_valid),
    .s1_ready (s1_ready),
    .s1_rd    (s1_rd),
    .m_a      (m_a),
    .m_we     (m_we),
    .m_wd     (m_wd),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_rd     (m_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave: accept after sl_d ISSUE cycles, complete sl_cd cycles after acceptance.
  logic [31:0] mem [0:15];
  int          sl_d  = 0;
  int          sl_cd = 0;
  int          sl_cnt = 0;
  int          sl_ph  = 0;
  logic [31:0] sl_a, sl_wd;
  logic        sl_we;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sl_ph   = 0;
      sl_cnt  = 0;
      m_ready = 1'b0;
    end else begin
      case (sl_ph)
        0: begin
          m_ready = 1'b0;
          if (m_valid) begin
            if (sl_cnt < sl_d) begin
              sl_cnt++;
            end else begin
              m_ready = 1'b1;
              sl_a    = m_a;
              sl_we   = m_we;
              sl_wd   = m_wd;
              sl_cnt  = 0;
              sl_ph   = 1;
            end
          end
        end
        1: begin
          if (sl_cnt < sl_cd) begin
            m_ready = 1'b0;
            sl_cnt++;
          end else begin
            m_ready = 1'b1;
            sl_cnt  = 0;
            if (sl_we) mem[sl_a[5:2]] = sl_wd;
            else       m_rd = mem[sl_a[5:2]];
            sl_ph = 2;
          end
        end
        default: begin
          m_ready = 1'b0;
          sl_ph   = 0;
        end
      endcase
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at an IDLE negedge; returns cycles from request to ready strobe.
  task automatic run_txn(input int port, input logic we, input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output int issue_cyc, output bit a_stable, output bit other_rdy);
    lat = -1;
    issue_cyc = 0;
    a_stable = 1'b1;
    other_rdy = 1'b0;
    if (port == 0) begin
      s0_a = a; s0_we = we; s0_wd = wd; s0_valid = 1'b1;
    end else begin
      s1_a = a; s1_we = we; s1_wd = wd; s1_valid = 1'b1;
    end
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (m_valid) begin
        issue_cyc++;
        if (m_a !== a || m_we !== we) a_stable = 1'b0;
      end
      if ((port == 0) ? s1_ready : s0_ready) other_rdy = 1'b1;
      if ((port == 0) ? s0_ready : s1_ready) begin
        lat = i;
        break;
      end
    end
    s0_valid = 1'b0;
    s1_valid = 1'b0;
    if (lat < 0) check("txn_timeout", 0, 1);
    @(negedge clk);
  endtask

  int         lat, icyc, n;
  bit         stable, other, got0, pulse;
  logic [3:0] order;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[4]  = 32'hDEAD_BEEF;
    mem[12] = 32'hA5A5_0001;
    mem[13] = 32'hA5A5_0002;
    m_rd = '0; m_ready = 1'b0;
    rst_n = 1'b0;
    s0_a = '0; s0_we = 1'b0; s0_wd = '0; s0_valid = 1'b0;
    s1_a = '0; s1_we = 1'b0; s1_wd = '0; s1_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_m_valid", m_valid, 0);
    check("rst_s0_ready", s0_ready, 0);
    check("rst_s1_ready", s1_ready, 0);
    check("rst_s0_rd", s0_rd, 0);
    check("rst_s1_rd", s1_rd, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Tie: both ports request continuously from a fresh reset.
    s0_a = 32'h30; s0_we = 1'b0; s1_a = 32'h34; s1_we = 1'b0;
    s0_valid = 1'b1; s1_valid = 1'b1;
    order = '0; n = 0;
    for (int i = 0; i < 200 && n < 4; i++) begin
      @(negedge clk);
      if (s0_ready) begin order = {order[2:0], 1'b0}; n++; end
      else if (s1_ready) begin order = {order[2:0], 1'b1}; n++; end
    end
    s1_valid = 1'b0;
    got0 = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s0_ready) begin got0 = 1'b1; break; end
    end
    s0_valid = 1'b0;
    @(negedge clk);
    check("tie_count", n, 4);
    check("tie_order", order, TIE_EXP);
    check("tie_s0_served", got0, 1);
    check("tie_s0_rd", s0_rd, 32'hA5A5_0001);
    check("tie_s1_rd", s1_rd, 32'hA5A5_0002);

    // Single read, port 0, slave delay 2.
    sl_d = 2;
    run_txn(0, 1'b0, 32'h10, 32'h0, lat, icyc, stable, other);
    check("rd0_latency", lat, 5);
    check("rd0_data", s0_rd, 32'hDEAD_BEEF);
    check("rd0_s1_quiet", other, 0);

    // Write then read, port 1, slave delay 0.
    sl_d = 0;
    run_txn(1, 1'b1, 32'h20, 32'h1234_5678, lat, icyc, stable, other);
    check("wr1_latency", lat, 3);
    check("wr1_rd_held", s1_rd, 32'hA5A5_0002);
    run_txn(1, 1'b0, 32'h20, 32'h0, lat, icyc, stable, other);
    check("rd1_latency", lat, 3);
    check("rd1_data", s1_rd, 32'h1234_5678);
    check("rd1_s0_rd_held", s0_rd, 32'hDEAD_BEEF);

    // Slave stall: m_ready low for 6 ISSUE cycles.
    sl_d = 6;
    run_txn(0, 1'b0, 32'h34, 32'h0, lat, icyc, stable, other);
    check("stall_latency", lat, 9);
    check("stall_issue_cycles", icyc, 7);
    check("stall_addr_stable", stable, 1);
    check("stall_no_other", other, 0);
    check("stall_data", s0_rd, 32'hA5A5_0002);

    // Reset while the transaction sits in WAIT.
    sl_d = 0; sl_cd = 4;
    s0_a = 32'h10; s0_we = 1'b0; s0_valid = 1'b1;
    @(negedge clk);
    check("wait_pre_mvalid_hi", m_valid, 1);
    @(negedge clk);
    check("wait_mvalid_lo", m_valid, 0);
    rst_n = 1'b0;
    s0_valid = 1'b0;
    #1;
    check("mid_rst_m_valid", m_valid, 0);
    check("mid_rst_s0_rd", s0_rd, 0);
    check("mid_rst_s1_rd", s1_rd, 0);
    pulse = s0_ready | s1_ready;
    repeat (2) begin
      @(negedge clk);
      pulse |= s0_ready | s1_ready;
    end
    rst_n = 1'b1;
    sl_cd = 0;
    repeat (4) begin
      @(negedge clk);
      pulse |= s0_ready | s1_ready | m_valid;
    end
    check("mid_rst_no_strobe", pulse, 0);
    run_txn(0, 1'b0, 32'h10, 32'h0, lat, icyc, stable, other);
    check("post_rst_latency", lat, 3);
    check("post_rst_data", s0_rd, 32'hDEAD_BEEF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
